vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
Parametrised VGA sync/timing generator; successor to the fixed 640x480 sync block that drives the time printer.
- Generates hsync, vsync, draw (active video) and pixel coordinates from one system clock, using an internal pixel-rate prescaler.
- Horizontal and vertical porch/sync widths, sync polarities and pixel divider are all parameters.
- Adds run enable, frame_start and line_start pulses, so downstream renderers (timeprinter successors) can latch per-frame/line data.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, hsync asserted level (0 = active-low)
V_POL, 0, vsync asserted level
CLK_DIV, 1, system clocks per pixel (>=1)
X_W, 10, x output width; must be >= clog2(H_TOTAL)
Y_W, 10, y output width; must be >= clog2(V_TOTAL)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
en  in  1  run enable; low freezes all counters
hsync  out  1  horizontal sync, level per H_POL
vsync  out  1  vertical sync, level per V_POL
draw  out  1  high while inside the active area
x  out  X_W  current horizontal counter (0..H_TOTAL-1)
y  out  Y_W  current vertical counter (0..V_TOTAL-1)
line_start  out  1  one-clk pulse when x becomes 0
frame_start  out  1  one-clk pulse when (x,y) becomes (0,0)

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Line order: active, front porch, sync, back porch.
- Width check: X_W/Y_W too small, or CLK_DIV<1, is an elaboration error.
- Prescaler:
  - div counts 0..CLK_DIV-1 while en=1.
  - pix_tick = en && div==CLK_DIV-1; with CLK_DIV=1, pix_tick=en.
  - en=0 freezes div.
- Counters:
  - On pix_tick, h increments and wraps H_TOTAL-1 -> 0.
  - On that wrap, v increments and wraps V_TOTAL-1 -> 0.
- Outputs:
  - All outputs are registers loaded from the next counter values, so x, y, hsync, vsync and draw are mutually aligned in every cycle.
  - No extra pipeline latency versus the counters.
- Decode:
  - hsync = H_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else ~H_POL; vsync analogous on v.
  - draw = (h < H_ACTIVE) && (v < V_ACTIVE).
- Pulses:
  - line_start = 1 for exactly one clk on the pix_tick edge that loads h=0.
  - frame_start additionally requires v=0.
  - Pulses are 0 on all other cycles, including while en=0.
- Reset (async, immediate, independent of clk):
  - Counters go to h=H_TOTAL-1, v=V_TOTAL-1, div=0.
  - Outputs: x=H_TOTAL-1, y=V_TOTAL-1, hsync=~H_POL, vsync=~V_POL, draw=0, line_start=0, frame_start=0.
  - First pix_tick after release loads (0,0) with draw=1, line_start=1, frame_start=1.
- en deasserted mid-line: every output holds its value; pulses deassert. Re-enable resumes from the held position and div value.
- reset asserted mid-operation overrides en and any pending tick.

Decomposition:
- Shared package vga_timing_pkg:
  - default 640x480@60 constants (H_ACTIVE..V_BP);
  - function total(a,fp,s,bp);
  - function in_range(cnt,lo,hi) for sync decode.
- One sub-module pix_tick_gen (CLK_DIV prescaler with en; outputs pix_tick).
- Counters and decode stay in vga_timing_gen.

Test Plan:
1. Default params, release reset, en=1 -> next clk: x=0, y=0, draw=1, line_start=1, frame_start=1.
2. Default params -> hsync low exactly for x=656..751 (96 clks/line); draw=0 for x=640..799; line_start period 800 clks.
3. Small params H=8/2/3/2 (total 15), V=4/1/2/1 (total 8), CLK_DIV=1:
   - vsync low only on y=5..6;
   - frame_start once per 120 clks;
   - x wraps 14 -> 0 with y incrementing on the same edge.
4. Small params, CLK_DIV=4, H_POL=1 -> x steps every 4 clks; hsync high for x=10..12 (12 clks); frame_start period 480 clks.
5. en=0 for 10 clks at x=100, y=3 (defaults) -> x, y, draw held, no pulses; after re-enable the next pix_tick gives x=101.
6. Assert reset mid-frame between clk edges -> outputs take reset values immediately (x=799, y=524, draw=0, syncs inactive); after release the first clk gives frame_start=1.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults) and small helpers
// used for totals and sync-window decode.
package vga_timing_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int total(input int a, input int fp, input int s, input int bp);
    return a + fp + s + bp;
  endfunction

  // Half-open window: lo <= cnt < hi
  function automatic bit in_range(input int cnt, input int lo, input int hi);
    return (cnt >= lo) && (cnt < hi);
  endfunction
endpackage

// File: rtl/vga_timing_gen_pix_tick.sv
// Pixel-rate prescaler: one pix_tick every CLK_DIV enabled system clocks.
module pix_tick_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic pix_tick
);
  // Keep a 1-bit counter even for CLK_DIV=1; it stays at 0 so pix_tick == en.
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   div <= '0;
    else if (en) div <= (div == DIV_MAX) ? '0 : div + 1'b1;
  end

  assign pix_tick = en && (div == DIV_MAX);
endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync/timing generator: h/v counters, sync/draw decode,
// and line/frame start pulses, all registered from the next counter values.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CLK_DIV  = 1,
  parameter int X_W      = 10,
  parameter int Y_W      = 10
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  output logic           hsync,
  output logic           vsync,
  output logic           draw,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           line_start,
  output logic           frame_start
);
  localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HS_LO   = H_ACTIVE + H_FP;
  localparam int VS_LO   = V_ACTIVE + V_FP;
  localparam logic [X_W-1:0] H_LAST = X_W'(H_TOTAL - 1);
  localparam logic [Y_W-1:0] V_LAST = Y_W'(V_TOTAL - 1);

  generate
    if (X_W < $clog2(H_TOTAL) || Y_W < $clog2(V_TOTAL) || CLK_DIV < 1) begin : g_bad_cfg
      $error("vga_timing_gen: X_W/Y_W too narrow for totals or CLK_DIV < 1");
    end
  endgenerate

  logic           pix_tick;
  logic [X_W-1:0] h, h_nxt;
  logic [Y_W-1:0] v, v_nxt;

  pix_tick_gen #(.CLK_DIV(CLK_DIV)) u_pix_tick (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .pix_tick (pix_tick)
  );

  always_comb begin
    h_nxt = h;
    v_nxt = v;
    if (pix_tick) begin
      if (h == H_LAST) begin
        h_nxt = '0;
        v_nxt = (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h_nxt = h + 1'b1;
      end
    end
  end

  // Decode from h_nxt/v_nxt so every output lines up with the counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h           <= H_LAST;
      v           <= V_LAST;
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
      draw        <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      h           <= h_nxt;
      v           <= v_nxt;
      hsync       <= in_range(int'(h_nxt), HS_LO, HS_LO + H_SYNC) ? H_POL : ~H_POL;
      vsync       <= in_range(int'(v_nxt), VS_LO, VS_LO + V_SYNC) ? V_POL : ~V_POL;
      draw        <= (int'(h_nxt) < H_ACTIVE) && (int'(v_nxt) < V_ACTIVE);
      line_start  <= pix_tick && (h_nxt == '0);
      frame_start <= pix_tick && (h_nxt == '0) && (v_nxt == '0);
    end
  end

  assign x = h;
  assign y = v;
endmodule
